// File: rtl/kernel_conv_mac_pkg.sv
// rtl/kernel_conv_mac_pkg.sv - shared constants and state encoding for the convolution engine
package kernel_conv_mac_pkg;

    localparam int KERN_TAPS = 7;
    localparam int KERN_SUM  = 222;
    localparam int PIX_W     = 8;
    localparam int COEF_W    = 8;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_MAC    = 2'd1,
        ST_NORM   = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

endpackage

// File: rtl/kernel_conv_mac_if.sv
// rtl/kernel_conv_mac_if.sv - sample input, kernel ROM and result output signals of the engine
interface kernel_conv_mac_if;
    import kernel_conv_mac_pkg::*;

    logic              in_sof;
    logic              in_valid;
    logic [PIX_W-1:0]  in_data;
    logic              in_ready;
    logic [2:0]        kern_addr;
    logic [COEF_W-1:0] kern_data;
    logic              out_valid;
    logic [PIX_W-1:0]  out_data;
    logic              out_ready;

    modport slave (
        input  in_sof, in_valid, in_data, kern_data, out_ready,
        output in_ready, kern_addr, out_valid, out_data
    );

    modport master (
        output in_sof, in_valid, in_data, kern_data, out_ready,
        input  in_ready, kern_addr, out_valid, out_data
    );

endinterface

// File: rtl/kernel_conv_mac_window.sv
// rtl/kernel_conv_mac_window.sv - 7-sample shift window with fill tracking and start-of-frame restart
module kernel_conv_mac_window
    import kernel_conv_mac_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            shift_en,
    input  logic                            sof,
    input  logic [PIX_W-1:0]                din,
    output logic [KERN_TAPS-1:0][PIX_W-1:0] win,
    output logic                            full_next
);

    logic [2:0] fill;
    logic [2:0] fill_nxt;

    // A start-of-frame beat counts as the first sample; stale entries stay in win but are not yet "full".
    always_comb begin
        fill_nxt = fill;
        if (shift_en) begin
            if (sof)
                fill_nxt = 3'd1;
            else if (fill != 3'(KERN_TAPS))
                fill_nxt = fill + 3'd1;
        end
    end

    assign full_next = (fill_nxt == 3'(KERN_TAPS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill <= '0;
            win  <= '0;
        end else begin
            fill <= fill_nxt;
            if (shift_en) begin
                for (int k = 0; k < KERN_TAPS - 1; k++)
                    win[k] <= win[k+1];
                win[KERN_TAPS-1] <= din;
            end
        end
    end

endmodule

// File: rtl/kernel_conv_mac.sv
// rtl/kernel_conv_mac.sv - 7-tap convolution with decimation, serial MAC and kernel-sum normalisation
module kernel_conv_mac
    import kernel_conv_mac_pkg::*;
#(
    parameter int DECIM      = 2,
    parameter int ACC_W      = 17,
    parameter int NORM_MUL   = 295,
    parameter int NORM_SHIFT = 16
) (
    input  logic             clk,
    input  logic             rst,
    kernel_conv_mac_if.slave bus
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int SC_W = ACC_W + 9;

    state_t                          state;
    state_t                          state_nxt;
    logic [2:0]                      cnt;
    logic [ACC_W-1:0]                acc;
    logic [PH_W-1:0]                 phase;
    logic                            out_valid_q;
    logic [PIX_W-1:0]                out_data_q;
    logic [KERN_TAPS-1:0][PIX_W-1:0] win;
    logic                            full_next;
    logic                            accept;
    logic                            trigger;
    logic                            handshake;
    logic [2:0]                      tap_idx;
    logic [PIX_W-1:0]                tap_pix;
    logic [PIX_W+COEF_W-1:0]         prod;
    logic [SC_W-1:0]                 scaled;
    logic [SC_W-1:0]                 shifted;
    logic [PIX_W-1:0]                norm_pix;

    kernel_conv_mac_window u_window (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (accept),
        .sof       (bus.in_sof),
        .din       (bus.in_data),
        .win       (win),
        .full_next (full_next)
    );

    assign bus.in_ready  = (state == ST_ACCEPT) && !rst;
    assign accept        = bus.in_valid && bus.in_ready;
    assign trigger       = accept && full_next && (phase == '0);
    assign handshake     = out_valid_q && bus.out_ready;
    assign bus.kern_addr = (state == ST_MAC && cnt != 3'd7) ? cnt : 3'd0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    // ROM data lags the address by one cycle, so cycle c multiplies coefficient c-1 with tap c-1.
    always_comb begin
        tap_idx = cnt - 3'd1;
        tap_pix = '0;
        for (int k = 0; k < KERN_TAPS; k++)
            if (tap_idx == 3'(k))
                tap_pix = win[k];
    end

    assign prod     = bus.kern_data * tap_pix;
    assign scaled   = SC_W'(acc) * SC_W'(NORM_MUL) + (SC_W'(1) << (NORM_SHIFT - 1));
    assign shifted  = scaled >> NORM_SHIFT;
    assign norm_pix = (shifted > SC_W'(255)) ? '1 : shifted[PIX_W-1:0];

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_ACCEPT: if (trigger)          state_nxt = ST_MAC;
            ST_MAC:    if (cnt == 3'd7)      state_nxt = ST_NORM;
            ST_NORM:                         state_nxt = ST_OUT;
            ST_OUT:    if (handshake)        state_nxt = ST_ACCEPT;
            default:                         state_nxt = ST_ACCEPT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_ACCEPT;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            acc         <= '0;
            phase       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (accept) begin
                if (bus.in_sof)
                    phase <= '0;
                else if (full_next)
                    phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + 1'b1;
            end
            unique case (state)
                ST_ACCEPT: begin
                    if (trigger) begin
                        cnt <= '0;
                        acc <= '0;
                    end
                end
                ST_MAC: begin
                    cnt <= cnt + 3'd1;
                    if (cnt != 3'd0)
                        acc <= acc + ACC_W'(prod);
                end
                ST_NORM: out_data_q <= norm_pix;
                // valid rises one cycle into OUT and drops on the cycle after the handshake
                ST_OUT:  out_valid_q <= !handshake;
                default: ;
            endcase
        end
    end

endmodule
